execute_port_wb_merge: RTL and testbench
========================================

Name: execute_port_wb_merge

Overview:
- Parametrised successor of the single-port ALU writeback stage.
- Merges one single-cycle ALU result stream with NUM_LL long-latency result channels (dividers, iterative multipliers) into one scheduler writeback per cycle.
- Single-cycle results are buffered in a DEPTH-entry FIFO instead of being locked out.
- Long-latency channels are round-robin arbitrated, with a starvation guard for the FIFO and a sticky exception lock; sits between the ALU datapath and scheduler1/scheduler2.

Parameters:
- DATA_W, 32: result data width.
- NUM_LL, 2: number of long-latency result channels (1..4).
- DEPTH, 4: single-cycle result FIFO entries (power of 2, >=2).
- DEPTH_N, 2: log2(DEPTH).
- STARVE_MAX, 3: consecutive FIFO-nonempty losses before the FIFO is forced to win.

Ports:
- iCLOCK  in  1  clock.
- iRESET_SYNC  in  1  synchronous active-high reset.
- iFREE_EX  in  1  pipeline flush.
- iALU_VALID  in  1  single-cycle result valid.
- iALU_PAYLOAD  in  PAY_W  {commit_tag[6], sysreg, regname[6], writeback, data[DATA_W], flag[5], flags_wb, flags_regname[4]}; PAY_W = DATA_W+24.
- iALU_EXCEPTION_VALID  in  1  result raises an exception.
- iALU_EXCEPTION_NUM  in  11  exception number.
- oALU_LOCK  out  1  upstream must not assert iALU_VALID in the same cycle.
- iLL_VALID  in  NUM_LL  per-channel result valid.
- iLL_PAYLOAD  in  NUM_LL*PAY_W  channel i occupies bits [i*PAY_W +: PAY_W].
- oLL_READY  out  NUM_LL  one-hot grant; the channel holds its payload until granted.
- oINTERRUPT_ACTIVE  out  1  one-cycle exception pulse.
- oINTERRUPT_NUM  out  11  exception number.
- oWB_VALID  out  1  writeback valid to scheduler1/scheduler2.
- oWB_PAYLOAD  out  PAY_W  writeback fields.
- oOVERFLOW  out  1  sticky error: push while full.

Behaviour:
- Reset is synchronous and active-high: on iRESET_SYNC high at a clock edge, all state clears.
  - FIFO count 0, pointers 0, rr_ptr 0, starve_cnt 0, lock_sticky 0, oOVERFLOW 0.
  - All outputs 0.
- Push: iALU_VALID && !lock_sticky && !iFREE_EX writes the payload at the tail.
  - The entry is visible at the FIFO head the next cycle, so the minimum ALU-to-writeback latency is 1 cycle.
- Arbitration is combinational each cycle.
  - If any iLL_VALID is high and starve_cnt < STARVE_MAX: grant the first valid channel at or after rr_ptr (wrapping); advance rr_ptr to granted+1 mod NUM_LL.
  - Else if the FIFO is nonempty: pop the head.
  - A long-latency channel is also granted when the FIFO is empty.
- starve_cnt:
  - Increments when the FIFO is nonempty and a long-latency channel wins.
  - Resets to 0 on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- oWB_VALID / oWB_PAYLOAD are combinational from the winner (granted channel payload or FIFO head); both are 0 when nothing is eligible.
  - The scheduler cannot stall, so a grant means retire.
- Simultaneous push and pop are both allowed; count is unchanged.
- oALU_LOCK = (count >= DEPTH-1) || lock_sticky.
- Push while count == DEPTH: entry dropped, oOVERFLOW set sticky until reset. This is an upstream contract violation and must not occur.
- Exception: on an accepted push with iALU_EXCEPTION_VALID high:
  - The entry is still queued.
  - oINTERRUPT_ACTIVE pulses high for the next cycle with oINTERRUPT_NUM.
  - lock_sticky is set; further ALU pushes are ignored until iFREE_EX.
  - oINTERRUPT_NUM holds its value until the next exception.
- iFREE_EX has priority over all events in the same cycle:
  - Clears the FIFO, starve_cnt and lock_sticky.
  - Forces oWB_VALID = 0 and oLL_READY = 0 for that cycle.
  - Long-latency channels are flushed by their own units.
  - rr_ptr and oOVERFLOW are kept.

Decomposition:
- Shared package: PAY_W field offsets, payload pack/unpack functions, and the EXCEPT_* codes used by the ALU.
- One sub-module: wb_merge_fifo (DATA width = PAY_W, DEPTH, DEPTH_N; push, pop, flush, count, head).
- Round-robin arbitration and the starvation counter stay in the top.

Test Plan:
- Reset with iALU_VALID=1 held, then 3 ALU pushes tags 1,2,3 with no long-latency traffic:
  - oWB_VALID high on cycles 1,2,3 after each push, tags 1,2,3 in order.
  - oALU_LOCK=0 throughout.
- NUM_LL=2, both channels valid continuously (tags 10,11), FIFO empty:
  - Grants alternate 0,1,0,1; oLL_READY one-hot.
- FIFO holds tags 1..3 while both long-latency channels are continuously valid, STARVE_MAX=3:
  - 3 long-latency wins, then FIFO tag 1.
  - Pattern repeats until the FIFO is empty.
- 4 pushes with no pops, DEPTH=4:
  - oALU_LOCK rises when count reaches 3.
  - A forced 5th push sets oOVERFLOW=1 and is dropped.
- Push tag 5 with exception num 0x003, then push tag 6:
  - Next cycle oINTERRUPT_ACTIVE=1, NUM=0x003.
  - Tag 6 is ignored and oALU_LOCK=1 until iFREE_EX, after which a push is accepted.
- iFREE_EX in the same cycle as a push, a long-latency valid and a FIFO of 2 entries:
  - oWB_VALID=0, oLL_READY=0, FIFO empty the next cycle.
  - The long-latency payload is granted afterwards if still valid.

Source files
------------

// File: rtl/execute_port_wb_merge_pkg.sv
// Shared definitions for the execute-port writeback merge: payload layout, helpers and
// the exception codes raised by the single-cycle ALU.
package execute_port_wb_merge_pkg;

  // Payload = {hdr, data[DATA_W], flg}; everything except data is fixed width.
  localparam int unsigned HDR_W      = 14;
  localparam int unsigned FLG_W      = 10;
  localparam int unsigned PAY_OVH_W  = HDR_W + FLG_W;
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_PAY_W  = MAX_DATA_W + PAY_OVH_W;

  typedef struct packed {
    logic [5:0] commit_tag;
    logic       sysreg;
    logic [5:0] regname;
    logic       writeback;
  } wb_hdr_t;

  typedef struct packed {
    logic [4:0] flag;
    logic       flags_wb;
    logic [3:0] flags_regname;
  } wb_flg_t;

  localparam logic [10:0] EXCEPT_NONE     = 11'h000;
  localparam logic [10:0] EXCEPT_DIV_ZERO = 11'h001;
  localparam logic [10:0] EXCEPT_OVERFLOW = 11'h002;
  localparam logic [10:0] EXCEPT_ILLEGAL  = 11'h003;

  function automatic int unsigned hdr_lsb(input int unsigned data_w);
    return data_w + FLG_W;
  endfunction

  // Packs into the widest supported payload; callers truncate to DATA_W + PAY_OVH_W.
  function automatic logic [MAX_PAY_W-1:0] pack_payload(input wb_hdr_t hdr,
                                                        input logic [MAX_DATA_W-1:0] data,
                                                        input wb_flg_t flg,
                                                        input int unsigned data_w);
    logic [MAX_PAY_W-1:0]  p;
    logic [MAX_DATA_W-1:0] mask;
    mask = (data_w >= MAX_DATA_W) ? '1 : ((MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1));
    p = MAX_PAY_W'(flg);
    p = p | (MAX_PAY_W'(data & mask) << FLG_W);
    p = p | (MAX_PAY_W'(hdr) << hdr_lsb(data_w));
    return p;
  endfunction

  function automatic wb_hdr_t unpack_hdr(input logic [MAX_PAY_W-1:0] p,
                                         input int unsigned data_w);
    return wb_hdr_t'(HDR_W'(p >> hdr_lsb(data_w)));
  endfunction

  function automatic wb_flg_t unpack_flg(input logic [MAX_PAY_W-1:0] p);
    return wb_flg_t'(FLG_W'(p));
  endfunction

endpackage

// File: rtl/execute_port_wb_merge_fifo.sv
// Single-cycle result FIFO: push at tail, pop at head, flush clears occupancy.
// Overflow is sticky and only cleared by reset.
module wb_merge_fifo #(
  parameter int unsigned DATA_W  = 56,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEPTH_N = 2
) (
  input  logic              iCLOCK,
  input  logic              iRESET_SYNC,
  input  logic              iFLUSH,
  input  logic              iPUSH,
  input  logic [DATA_W-1:0] iPUSH_DATA,
  input  logic              iPOP,
  output logic [DEPTH_N:0]  oCOUNT,
  output logic [DATA_W-1:0] oHEAD,
  output logic              oEMPTY,
  output logic              oOVERFLOW
);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_N-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_N:0]   count_q;
  logic               overflow_q;
  logic               full, empty, push_ok, pop_ok;

  always_comb begin
    full    = (count_q == (DEPTH_N+1)'(DEPTH));
    empty   = (count_q == '0);
    push_ok = iPUSH && !full && !iFLUSH;
    pop_ok  = iPOP && !empty && !iFLUSH;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // A push into a full FIFO is dropped even if a pop retires the head this cycle.
      if (iPUSH && full) overflow_q <= 1'b1;
      if (iFLUSH) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_N'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_N'(1);
        count_q <= count_q + (DEPTH_N+1)'(push_ok) - (DEPTH_N+1)'(pop_ok);
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push_ok) mem_q[wr_ptr_q] <= iPUSH_DATA;
  end

  assign oCOUNT    = count_q;
  assign oHEAD     = mem_q[rd_ptr_q];
  assign oEMPTY    = empty;
  assign oOVERFLOW = overflow_q;

endmodule

// File: rtl/execute_port_wb_merge.sv
// Merges the single-cycle ALU result stream (buffered) with round-robin arbitrated
// long-latency channels into one scheduler writeback per cycle.
module execute_port_wb_merge
  import execute_port_wb_merge_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_LL     = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTH_N    = 2,
  parameter int unsigned STARVE_MAX = 3,
  localparam int unsigned PAY_W     = DATA_W + PAY_OVH_W
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET_SYNC,
  input  logic                    iFREE_EX,
  input  logic                    iALU_VALID,
  input  logic [PAY_W-1:0]        iALU_PAYLOAD,
  input  logic                    iALU_EXCEPTION_VALID,
  input  logic [10:0]             iALU_EXCEPTION_NUM,
  output logic                    oALU_LOCK,
  input  logic [NUM_LL-1:0]       iLL_VALID,
  input  logic [NUM_LL*PAY_W-1:0] iLL_PAYLOAD,
  output logic [NUM_LL-1:0]       oLL_READY,
  output logic                    oINTERRUPT_ACTIVE,
  output logic [10:0]             oINTERRUPT_NUM,
  output logic                    oWB_VALID,
  output logic [PAY_W-1:0]        oWB_PAYLOAD,
  output logic                    oOVERFLOW
);

  localparam int unsigned RR_W     = (NUM_LL > 1) ? $clog2(NUM_LL) : 1;
  localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [RR_W-1:0]     rr_q, rr_d, grant_idx;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                lock_q, lock_d;
  logic                irq_q, irq_d;
  logic [10:0]         irq_num_q, irq_num_d;

  logic                alu_push, fifo_pop, ll_win, starved;
  logic                fifo_empty;
  logic [DEPTH_N:0]    fifo_count;
  logic [PAY_W-1:0]    fifo_head;

  // First valid channel at or after ptr, wrapping.
  function automatic logic [RR_W-1:0] rr_pick(input logic [NUM_LL-1:0] valid,
                                              input logic [RR_W-1:0] ptr);
    logic [RR_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_LL; k++) begin
      idx = (32'(ptr) + k) % NUM_LL;
      if (!found && valid[RR_W'(idx)]) begin
        found = 1'b1;
        pick  = RR_W'(idx);
      end
    end
    return pick;
  endfunction

  wb_merge_fifo #(
    .DATA_W  (PAY_W),
    .DEPTH   (DEPTH),
    .DEPTH_N (DEPTH_N)
  ) u_fifo (
    .iCLOCK     (iCLOCK),
    .iRESET_SYNC(iRESET_SYNC),
    .iFLUSH     (iFREE_EX),
    .iPUSH      (alu_push),
    .iPUSH_DATA (iALU_PAYLOAD),
    .iPOP       (fifo_pop),
    .oCOUNT     (fifo_count),
    .oHEAD      (fifo_head),
    .oEMPTY     (fifo_empty),
    .oOVERFLOW  (oOVERFLOW)
  );

  always_comb begin
    grant_idx = rr_pick(iLL_VALID, rr_q);
    starved   = (starve_q >= STARVE_W'(STARVE_MAX));
    ll_win    = !iFREE_EX && (|iLL_VALID) && (!starved || fifo_empty);
    fifo_pop  = !iFREE_EX && !ll_win && !fifo_empty;
    alu_push  = iALU_VALID && !lock_q && !iFREE_EX;

    oLL_READY   = '0;
    oWB_VALID   = 1'b0;
    oWB_PAYLOAD = '0;
    if (ll_win) begin
      oLL_READY[grant_idx] = 1'b1;
      oWB_VALID            = 1'b1;
      oWB_PAYLOAD          = iLL_PAYLOAD[grant_idx*PAY_W +: PAY_W];
    end else if (fifo_pop) begin
      oWB_VALID   = 1'b1;
      oWB_PAYLOAD = fifo_head;
    end

    oALU_LOCK = (fifo_count >= (DEPTH_N+1)'(DEPTH - 1)) || lock_q;

    rr_d = rr_q;
    if (ll_win) rr_d = RR_W'((32'(grant_idx) + 1) % NUM_LL);

    starve_d = starve_q;
    if (iFREE_EX || fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (ll_win && !starved) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    lock_d = lock_q;
    if (iFREE_EX) begin
      lock_d = 1'b0;
    end else if (alu_push && iALU_EXCEPTION_VALID) begin
      lock_d = 1'b1;
    end

    irq_d     = alu_push && iALU_EXCEPTION_VALID;
    irq_num_d = irq_d ? iALU_EXCEPTION_NUM : irq_num_q;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      rr_q      <= '0;
      starve_q  <= '0;
      lock_q    <= 1'b0;
      irq_q     <= 1'b0;
      irq_num_q <= EXCEPT_NONE;
    end else begin
      rr_q      <= rr_d;
      starve_q  <= starve_d;
      lock_q    <= lock_d;
      irq_q     <= irq_d;
      irq_num_q <= irq_num_d;
    end
  end

  assign oINTERRUPT_ACTIVE = irq_q;
  assign oINTERRUPT_NUM    = irq_num_q;

endmodule

// File: tb/tb_execute_port_wb_merge.sv
// Directed bench for execute_port_wb_merge with a writeback scoreboard queue.
module tb_execute_port_wb_merge;
  import execute_port_wb_merge_pkg::*;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_LL     = 2;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DEPTH_N    = 2;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned PAY_W      = DATA_W + PAY_OVH_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    free_ex = 1'b0;
  logic                    alu_valid = 1'b0;
  logic [PAY_W-1:0]        alu_payload = '0;
  logic                    exc_valid = 1'b0;
  logic [10:0]             exc_num = '0;
  logic [NUM_LL-1:0]       ll_valid = '0;
  logic [NUM_LL*PAY_W-1:0] ll_payload = '0;
  logic                    alu_lock, irq, wb_valid, overflow;
  logic [NUM_LL-1:0]       ll_ready;
  logic [10:0]             irq_num;
  logic [PAY_W-1:0]        wb_payload;

  int total = 0;
  int bad   = 0;
  logic [PAY_W:0] exp_q[$];

  always #5 clk = ~clk;

  execute_port_wb_merge #(
    .DATA_W    (DATA_W),
    .NUM_LL    (NUM_LL),
    .DEPTH     (DEPTH),
    .DEPTH_N   (DEPTH_N),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .iCLOCK              (clk),
    .iRESET_SYNC         (rst),
    .iFREE_EX            (free_ex),
    .iALU_VALID          (alu_valid),
    .iALU_PAYLOAD        (alu_payload),
    .iALU_EXCEPTION_VALID(exc_valid),
    .iALU_EXCEPTION_NUM  (exc_num),
    .oALU_LOCK           (alu_lock),
    .iLL_VALID           (ll_valid),
    .iLL_PAYLOAD         (ll_payload),
    .oLL_READY           (ll_ready),
    .oINTERRUPT_ACTIVE   (irq),
    .oINTERRUPT_NUM      (irq_num),
    .oWB_VALID           (wb_valid),
    .oWB_PAYLOAD         (wb_payload),
    .oOVERFLOW           (overflow)
  );

  function automatic logic [PAY_W-1:0] mk(input logic [5:0] t);
    wb_hdr_t h;
    wb_flg_t f;
    h.commit_tag    = t;
    h.sysreg        = t[0];
    h.regname       = ~t;
    h.writeback     = 1'b1;
    f.flag          = t[4:0];
    f.flags_wb      = t[1];
    f.flags_regname = t[3:0];
    return PAY_W'(pack_payload(h, {32'd0, {4{2'b10, t}}}, f, DATA_W));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_tag(input logic [5:0] t);
    exp_q.push_back({1'b1, mk(t)});
  endtask

  task automatic exp_idle();
    exp_q.push_back('0);
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic chk_wb(input string nm);
    logic [PAY_W:0] e;
    wb_hdr_t        h;
    total++;
    h = unpack_hdr(MAX_PAY_W'(wb_payload), DATA_W);
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed valid=%0b tag=%0d expected=<scoreboard empty>", nm, wb_valid,
             h.commit_tag);
    end else begin
      e = exp_q.pop_front();
      assert ({wb_valid, wb_payload} === e) else begin
        bad++;
        $error("FAIL %s observed valid=%0b tag=%0d payload=%0h expected valid=%0b payload=%0h",
               nm, wb_valid, h.commit_tag, wb_payload, e[PAY_W], e[PAY_W-1:0]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  int t3[13] = '{10, 11, 10, 11, 1, 10, 11, 10, 2, 11, 10, 11, 3};
  int t4[9]  = '{10, 11, 10, 11, 21, 22, 23, 24, 0};
  int l4[9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};

  initial begin
    ll_payload = {mk(6'd11), mk(6'd10)};

    // Reset with an ALU push held: nothing may be queued.
    alu_valid   = 1'b1;
    alu_payload = mk(6'd1);
    do_reset();
    #1;
    chk("reset_irq", 32'(irq), 0);
    chk("reset_irq_num", 32'(irq_num), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_ll_ready", 32'(ll_ready), 0);
    for (int i = 0; i < 5; i++) begin
      alu_valid   = (i < 3);
      alu_payload = mk(6'(i + 1));
      #1;
      if (i == 0) exp_idle();
      chk_wb("t1_wb");
      chk("t1_lock", 32'(alu_lock), 0);
      if (i < 3) exp_tag(6'(i + 1));
      else exp_idle();
      tick();
    end

    // Both channels valid with an empty FIFO: grants alternate.
    alu_valid = 1'b0;
    ll_valid  = 2'b11;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_tag((i % 2 == 0) ? 6'd10 : 6'd11);
      chk_wb("t2_wb");
      chk("t2_ready", 32'(ll_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end

    // FIFO competes with continuous long-latency traffic.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      alu_valid   = (i < 3);
      alu_payload = mk(6'(i + 1));
      #1;
      exp_tag(6'(t3[i]));
      chk_wb("t3_wb");
      tick();
    end
    alu_valid = 1'b0;
    ll_valid  = '0;
    #1;
    exp_idle();
    chk_wb("t3_drained");

    // Fill to DEPTH, then an illegal fifth push.
    ll_valid = 2'b11;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      alu_valid   = (i < 5);
      alu_payload = mk(6'(21 + i));
      ll_valid    = (i < 5) ? 2'b11 : 2'b00;
      #1;
      if (t4[i] == 0) exp_idle();
      else exp_tag(6'(t4[i]));
      chk_wb("t4_wb");
      chk("t4_lock", 32'(alu_lock), 32'(l4[i]));
      if (i == 4) chk("t4_overflow_pre", 32'(overflow), 0);
      if (i == 5) chk("t4_overflow", 32'(overflow), 1);
      tick();
    end
    alu_valid = 1'b0;
    free_ex   = 1'b1;
    tick();
    free_ex = 1'b0;
    #1;
    chk("t4_overflow_kept", 32'(overflow), 1);

    // Exception locks the ALU until a flush.
    ll_valid = '0;
    do_reset();
    alu_valid   = 1'b1;
    alu_payload = mk(6'd5);
    exc_valid   = 1'b1;
    exc_num     = 11'h003;
    #1;
    exp_idle();
    chk_wb("t5_c0_wb");
    chk("t5_c0_irq", 32'(irq), 0);
    tick();
    alu_payload = mk(6'd6);
    exc_valid   = 1'b0;
    exc_num     = 11'h000;
    #1;
    exp_tag(6'd5);
    chk_wb("t5_c1_wb");
    chk("t5_c1_irq", 32'(irq), 1);
    chk("t5_c1_irq_num", 32'(irq_num), 32'h003);
    chk("t5_c1_lock", 32'(alu_lock), 1);
    tick();
    alu_valid = 1'b0;
    #1;
    exp_idle();
    chk_wb("t5_c2_wb");
    chk("t5_c2_irq", 32'(irq), 0);
    chk("t5_c2_irq_num", 32'(irq_num), 32'h003);
    chk("t5_c2_lock", 32'(alu_lock), 1);
    tick();
    free_ex = 1'b1;
    #1;
    exp_idle();
    chk_wb("t5_c3_wb");
    tick();
    free_ex     = 1'b0;
    alu_valid   = 1'b1;
    alu_payload = mk(6'd7);
    #1;
    chk("t5_c4_lock", 32'(alu_lock), 0);
    exp_idle();
    chk_wb("t5_c4_wb");
    tick();
    alu_valid = 1'b0;
    #1;
    exp_tag(6'd7);
    chk_wb("t5_c5_wb");

    // Flush collides with a push, a long-latency valid and two queued entries.
    ll_valid = 2'b01;
    do_reset();
    alu_valid   = 1'b1;
    alu_payload = mk(6'd31);
    #1;
    exp_tag(6'd10);
    chk_wb("t6_c0_wb");
    tick();
    alu_payload = mk(6'd32);
    #1;
    exp_tag(6'd10);
    chk_wb("t6_c1_wb");
    tick();
    alu_payload = mk(6'd33);
    free_ex     = 1'b1;
    #1;
    exp_idle();
    chk_wb("t6_flush_wb");
    chk("t6_flush_ready", 32'(ll_ready), 0);
    tick();
    free_ex   = 1'b0;
    alu_valid = 1'b0;
    #1;
    exp_tag(6'd10);
    chk_wb("t6_after_wb");
    chk("t6_after_ready", 32'(ll_ready), 1);
    tick();
    ll_valid = '0;
    #1;
    exp_idle();
    chk_wb("t6_empty_wb");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
